// File: rtl/multiway_traffic_ctrl.sv
// Multi-direction traffic-light controller: round-robin green service with min/max extension.
// Optional emergency preemption is compiled in when TRAFFIC_EMERGENCY_EN is defined.
module multiway_traffic_ctrl #(
  parameter int unsigned NUM_DIR   = 4,
  parameter int unsigned MIN_GREEN = 8,
  parameter int unsigned MAX_GREEN = 32,
  parameter int unsigned YELLOW_T  = 4,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned TW        = 6,
  localparam int unsigned DW       = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [NUM_DIR-1:0] det,
`ifdef TRAFFIC_EMERGENCY_EN
  input  logic               emerg_req,
  input  logic [DW-1:0]      emerg_dir,
`endif
  output logic [NUM_DIR-1:0] red,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] green,
  output logic [DW-1:0]      cur_dir,
  output logic [1:0]         phase
);

  // Encodings double as the phase output.
  typedef enum logic [1:0] {
    StAllRed = 2'b00,
    StGreen  = 2'b01,
    StYellow = 2'b10
  } state_e;

  localparam logic [TW-1:0] MinG    = TW'(MIN_GREEN);
  localparam logic [TW-1:0] MaxG    = TW'(MAX_GREEN);
  localparam logic [TW-1:0] YellowT = TW'(YELLOW_T);
  localparam logic [TW-1:0] AllRedT = TW'(ALLRED_T);

  state_e             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d, t_inc;
  logic [DW-1:0]      cur_q, cur_d, next_dir;
  logic [NUM_DIR-1:0] demand_q, demand_d, cur_mask, enter_mask;
  logic               other;

  // First demanded direction after cur, wrapping; cur itself is checked last.
  function automatic logic [DW-1:0] rr_pick(input logic [DW-1:0] cur,
                                            input logic [NUM_DIR-1:0] dem);
    logic [DW-1:0] pick;
    logic [DW-1:0] idx;
    pick = cur;
    for (int k = int'(NUM_DIR); k > 0; k--) begin
      idx = DW'((int'(cur) + k) % int'(NUM_DIR));
      if (dem[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign cur_mask = {{(NUM_DIR-1){1'b0}}, 1'b1} << cur_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StAllRed;
      timer_q  <= '0;
      cur_q    <= '0;
      demand_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cur_q    <= cur_d;
      demand_q <= demand_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    t_inc    = (timer_q >= MaxG) ? MaxG : timer_q + 1'b1;
    other    = |(demand_q & ~cur_mask);
    next_dir = rr_pick(cur_q, demand_q);
`ifdef TRAFFIC_EMERGENCY_EN
    if (emerg_req) next_dir = emerg_dir;
`endif
    unique case (state_q)
      StAllRed: begin
        if (tick && t_inc >= AllRedT) begin
          state_d = StGreen;
          cur_d   = next_dir;
        end
      end
      StGreen: begin
`ifdef TRAFFIC_EMERGENCY_EN
        if (emerg_req) begin
          if (emerg_dir != cur_q) state_d = StYellow;
        end else
`endif
        if (tick && other && ((t_inc >= MinG && !det[cur_q]) || t_inc >= MaxG)) begin
          state_d = StYellow;
        end
      end
      StYellow: begin
        if (tick && t_inc >= YellowT) state_d = StAllRed;
      end
      default: state_d = StAllRed;
    endcase

    if (state_d != state_q) timer_d = '0;
    else if (tick)          timer_d = t_inc;
    else                    timer_d = timer_q;

    // Entering green clears that direction's demand, overriding a same-cycle detect.
    enter_mask = '0;
    if (state_q != StGreen && state_d == StGreen) begin
      enter_mask = {{(NUM_DIR-1){1'b0}}, 1'b1} << cur_d;
    end
    demand_d = (demand_q | det) & ~enter_mask;
  end

  always_comb begin
    green   = (state_q == StGreen)  ? cur_mask : '0;
    yellow  = (state_q == StYellow) ? cur_mask : '0;
    red     = ~(green | yellow);
    cur_dir = cur_q;
    phase   = state_q;
  end

endmodule

// File: tb/tb_multiway_traffic_ctrl.sv
// Bench for multiway_traffic_ctrl: vector table with scoreboard queue plus multi-cycle sequences.
module tb_multiway_traffic_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b1;
  logic [3:0] det = 4'h0;
  logic [3:0] red, yellow, green;
  logic [1:0] cur_dir, phase;
  logic       emerg_req = 1'b0;
  logic [1:0] emerg_dir = 2'd0;

  logic [3:0] det_hold = 4'h0;
  logic [3:0] det_pulse = 4'h0;
  int tests = 0, fails = 0, inv_bad = 0;
  int tick_div = 1, edge_cnt = 0;

  typedef struct {
    logic [3:0] det;
    logic [3:0] g;
    logic [3:0] y;
    logic [1:0] ph;
    logic [1:0] cur;
  } vec_t;

  vec_t vecs[16];
  vec_t sb[$];

  multiway_traffic_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .det      (det),
`ifdef TRAFFIC_EMERGENCY_EN
    .emerg_req(emerg_req),
    .emerg_dir(emerg_dir),
`endif
    .red      (red),
    .yellow   (yellow),
    .green    (green),
    .cur_dir  (cur_dir),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, settle; track the lamp invariant on every cycle.
  task automatic step();
    logic [3:0] gy;
    det  = det_hold | det_pulse;
    tick = (edge_cnt % tick_div) == 0;
    @(posedge clk);
    #1;
    edge_cnt++;
    det_pulse = 4'h0;
    gy = green | yellow;
    if (red !== ~gy || !$onehot0(gy)) inv_bad++;
  endtask

  task automatic wait_phase(input logic [1:0] target, input int budget, input string name,
                            output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (phase !== target && n < budget);
    if (phase !== target) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout, phase %0d wanted %0d after %0d cycles", name, phase, target, n);
    end
  endtask

  task automatic setv(input int i, input logic [3:0] d, input logic [3:0] g, input logic [3:0] y,
                      input logic [1:0] ph, input logic [1:0] cur);
    vecs[i].det = d;
    vecs[i].g   = g;
    vecs[i].y   = y;
    vecs[i].ph  = ph;
    vecs[i].cur = cur;
  endtask

  initial begin
    int   n;
    int   bad;
    vec_t e;
    logic [3:0] exp_red;

    // Release, single call on direction 2 at the fourth green cycle, then service of 2.
    for (int i = 0; i < 8; i++)   setv(i, (i == 3) ? 4'h4 : 4'h0, 4'h1, 4'h0, 2'd1, 2'd0);
    for (int i = 8; i < 12; i++)  setv(i, 4'h0, 4'h0, 4'h1, 2'd2, 2'd0);
    setv(12, 4'h0, 4'h0, 4'h0, 2'd0, 2'd0);
    for (int i = 13; i < 16; i++) setv(i, 4'h0, 4'h4, 4'h0, 2'd1, 2'd2);

    #12;
    chk("rst_red", red, 4'hF);
    chk("rst_yellow", yellow, 4'h0);
    chk("rst_green", green, 4'h0);
    chk("rst_phase", phase, 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("release_allred", phase, 2'd0);

    for (int i = 0; i < 16; i++) begin
      det_hold = vecs[i].det;
      sb.push_back(vecs[i]);
      step();
      e = sb.pop_front();
      exp_red = ~(e.g | e.y);
      chk($sformatf("vec%0d_green", i), green, e.g);
      chk($sformatf("vec%0d_yellow", i), yellow, e.y);
      chk($sformatf("vec%0d_red", i), red, exp_red);
      chk($sformatf("vec%0d_phase", i), phase, e.ph);
      chk($sformatf("vec%0d_cur", i), cur_dir, e.cur);
    end
    det_hold = 4'h0;

    // Round-robin from 2 with demand on 1 and 3: serve 3, then wrap to 1.
    det_pulse = 4'b1010;
    wait_phase(2'd2, 30, "rr_leave2", n);
    chk("rr_yellow_cur", cur_dir, 2'd2);
    wait_phase(2'd1, 10, "rr_enter3", n);
    chk("rr_cur3", cur_dir, 2'd3);
    chk("rr_green3", green, 4'b1000);
    wait_phase(2'd2, 40, "rr_leave3", n);
    chk("rr_green3_len", n, 8);
    wait_phase(2'd1, 10, "rr_enter1", n);
    chk("rr_cur1", cur_dir, 2'd1);
    chk("rr_green1", green, 4'b0010);

    // Rest in green with no other demand; timer must saturate, not wrap.
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (green !== 4'b0010) bad++;
    end
    chk("rest_green", bad, 0);
    det_hold  = 4'b0010;
    det_pulse = 4'b1000;
    step();
    chk("sat_hold", phase, 2'd1);
    step();
    chk("sat_exit", phase, 2'd2);
    det_hold = 4'h0;
    step();

    // Asynchronous reset in the middle of yellow.
    #2;
    rst_n = 1'b0;
    #1;
    chk("midy_red", red, 4'hF);
    chk("midy_yellow", yellow, 4'h0);
    chk("midy_phase", phase, 2'd0);
    chk("midy_cur", cur_dir, 2'd0);

    // Extension: det[0] held, demand on 1 -> green0 lasts exactly MAX_GREEN ticks.
    det_hold = 4'b0001;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("ext_entry_phase", phase, 2'd1);
    chk("ext_entry_cur", cur_dir, 2'd0);
    det_pulse = 4'b0010;
    wait_phase(2'd2, 60, "ext_leave", n);
    chk("ext_green_len", n, 32);

    // Same with tick every third cycle: durations scale by three.
    #2;
    rst_n = 1'b0;
    tick_div = 3;
    edge_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_phase(2'd1, 10, "slow_enter", n);
    chk("slow_entry_cur", cur_dir, 2'd0);
    det_pulse = 4'b0010;
    wait_phase(2'd2, 200, "slow_leave", n);
    chk("slow_green_len", n, 96);
    wait_phase(2'd0, 60, "slow_yellow", n);
    chk("slow_yellow_len", n, 12);
    tick_div = 1;
    det_hold = 4'h0;

`ifdef TRAFFIC_EMERGENCY_EN
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_phase(2'd1, 10, "em_enter0", n);
    step();
    step();
    emerg_req = 1'b1;
    emerg_dir = 2'd3;
    step();
    chk("em_preempt_yellow", yellow, 4'b0001);
    wait_phase(2'd1, 20, "em_enter3", n);
    chk("em_green3", green, 4'b1000);
    det_hold = 4'b0001;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (green !== 4'b1000) bad++;
    end
    chk("em_hold", bad, 0);
    emerg_req = 1'b0;
    det_hold  = 4'h0;
`endif

    chk("lamp_invariant", inv_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
